// File: rtl/numbers_reduce_pkg.sv
// Shared types and reduction identity values for the frame reduction sequencer.
package numbers_reduce_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic RED_AND_ID = 1'b1;
    localparam logic RED_OR_ID  = 1'b0;
    localparam logic RED_XOR_ID = 1'b0;

endpackage

// File: rtl/numbers_reduce_word.sv
// Combinational AND/OR/XOR reduction of a single input word.
module numbers_reduce_word #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    output logic              and_o,
    output logic              or_o,
    output logic              xor_o
);

    assign and_o = &data_i;
    assign or_o  = |data_i;
    assign xor_o = ^data_i;

endmodule

// File: rtl/numbers_reduce_seq.sv
// Frame reduction sequencer: folds per-word reductions into frame-wide AND/OR/parity
// and presents one result beat per frame.
//
// state | meaning
// ACCUM | accepting words and folding them into the accumulators
// DRAIN | frame overran MAX_WORDS; discarding words until in_last
// HOLD  | result valid, waiting for out_ready
module numbers_reduce_seq
    import numbers_reduce_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_WORDS = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_and,
    output logic                           out_or,
    output logic                           out_xor,
    output logic [$clog2(MAX_WORDS+1)-1:0] out_count,
    output logic                           out_trunc
);

    localparam int               CNT_W   = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

    state_e           state_q;
    logic             acc_and_q, acc_or_q, acc_xor_q, trunc_q;
    logic             acc_and_d, acc_or_d, acc_xor_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_and, w_or, w_xor;

    numbers_reduce_word #(.DATA_W(DATA_W)) u_word (
        .data_i (in_data),
        .and_o  (w_and),
        .or_o   (w_or),
        .xor_o  (w_xor)
    );

    assign acc_and_d = acc_and_q & w_and;
    assign acc_or_d  = acc_or_q  | w_or;
    assign acc_xor_d = acc_xor_q ^ w_xor;
    assign count_d   = count_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            acc_and_q <= RED_AND_ID;
            acc_or_q  <= RED_OR_ID;
            acc_xor_q <= RED_XOR_ID;
            count_q   <= '0;
            trunc_q   <= 1'b0;
        end else if (clr) begin
            state_q   <= ACCUM;
            acc_and_q <= RED_AND_ID;
            acc_or_q  <= RED_OR_ID;
            acc_xor_q <= RED_XOR_ID;
            count_q   <= '0;
            trunc_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        acc_and_q <= acc_and_d;
                        acc_or_q  <= acc_or_d;
                        acc_xor_q <= acc_xor_d;
                        count_q   <= count_d;
                        if (in_last) begin
                            trunc_q <= 1'b0;
                            state_q <= HOLD;
                        end else if (count_d == CNT_MAX) begin
                            trunc_q <= 1'b1;
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (in_valid && in_last) state_q <= HOLD;
                end
                HOLD: begin
                    // Identity reload on the transfer edge so the next frame starts clean.
                    if (out_ready) begin
                        state_q   <= ACCUM;
                        acc_and_q <= RED_AND_ID;
                        acc_or_q  <= RED_OR_ID;
                        acc_xor_q <= RED_XOR_ID;
                        count_q   <= '0;
                        trunc_q   <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM) || (state_q == DRAIN);
    assign out_valid = (state_q == HOLD);
    assign out_and   = acc_and_q;
    assign out_or    = acc_or_q;
    assign out_xor   = acc_xor_q;
    assign out_count = count_q;
    assign out_trunc = trunc_q;

endmodule

// File: tb/tb_numbers_reduce_seq.sv
// Self-checking bench for numbers_reduce_seq with MAX_WORDS=4 so truncation is reachable.
module tb_numbers_reduce_seq;

    localparam int DW = 8;
    localparam int MW = 4;
    localparam logic [6:0] IDENT = 7'b100_000_0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_and, out_or, out_xor, out_trunc;
    logic [2:0] out_count;
    logic [6:0] got;

    int n_vec = 0;
    int n_err = 0;

    numbers_reduce_seq #(.DATA_W(DW), .MAX_WORDS(MW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_and   (out_and),
        .out_or    (out_or),
        .out_xor   (out_xor),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    always #5 clk = ~clk;

    assign got = {out_and, out_or, out_xor, out_count, out_trunc};

    typedef struct {
        logic [7:0] w[6];
        int         n;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b required %b at %0t", nm, act, req, $time);
        end
    endtask

    // Frame result from first principles: only the first MW words count.
    function automatic logic [6:0] model(input logic [7:0] q[$]);
        int   n = q.size();
        int   cnt = (n > MW) ? MW : n;
        logic a = 1'b1;
        logic o = 1'b0;
        int   ones = 0;
        for (int i = 0; i < cnt; i++) begin
            a    = a & (q[i] == 8'hFF);
            o    = o | (q[i] != 8'h00);
            ones = ones + $countones(q[i]);
        end
        return {a, o, ones[0], 3'(cnt), (n > MW)};
    endfunction

    // All tasks start and end just after a rising edge.
    task automatic drive_beat(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        check("beat_in_ready", 7'(in_ready), 7'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_last = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] q[$], input bit gaps);
        for (int i = 0; i < q.size(); i++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive_beat(q[i], (i == q.size() - 1));
        end
    endtask

    task automatic take_result(input logic [6:0] exp, input int bp);
        @(negedge clk);
        check("latency_valid", 7'(out_valid), 7'd1);
        check("result", got, exp);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_result", got, exp);
            check("hold_in_ready", 7'(in_ready), 7'd0);
            check("hold_valid", 7'(out_valid), 7'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        @(negedge clk);
        check("post_xfer_valid", 7'(out_valid), 7'd0);
        check("post_xfer_in_ready", 7'(in_ready), 7'd1);
        check("post_xfer_ident", got, IDENT);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] q[$];

        tbl[0] = '{w: '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, exp: 7'b110_001_0};
        tbl[1] = '{w: '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2, exp: 7'b011_010_0};
        tbl[2] = '{w: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, exp: 7'b000_001_0};
        tbl[3] = '{w: '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, n: 6, exp: 7'b110_100_1};
        tbl[4] = '{w: '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, exp: 7'b011_001_0};
        tbl[5] = '{w: '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00}, n: 4, exp: 7'b110_100_0};
        tbl[6] = '{w: '{8'h07, 8'hF0, 8'h00, 8'h01, 8'h80, 8'h00}, n: 5, exp: 7'b010_100_1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", got, IDENT);
        check("reset_valid", 7'(out_valid), 7'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            q.delete();
            for (int j = 0; j < tbl[i].n; j++) q.push_back(tbl[i].w[j]);
            send_frame(q, 1'b0);
            take_result(tbl[i].exp, (i == 0) ? 5 : 1);
        end

        // clr on beat 2 of a 3-beat frame drops the beat and the partial frame
        drive_beat(8'h00, 1'b0);
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("clr_ident", got, IDENT);
        check("clr_valid", 7'(out_valid), 7'd0);
        check("clr_in_ready", 7'(in_ready), 7'd1);
        @(posedge clk); #1;
        q = '{8'h80};
        send_frame(q, 1'b0);
        take_result(7'b011_001_0, 0);

        // clr while a result is pending discards it
        drive_beat(8'hFF, 1'b1);
        @(negedge clk);
        check("clr_hold_pre_valid", 7'(out_valid), 7'd1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check("clr_hold_valid", 7'(out_valid), 7'd0);
        check("clr_hold_ident", got, IDENT);
        @(posedge clk); #1;

        // asynchronous reset mid-frame
        drive_beat(8'h00, 1'b0);
        drive_beat(8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ident", got, IDENT);
        check("rst_mid_valid", 7'(out_valid), 7'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        q = '{8'hFF};
        send_frame(q, 1'b0);
        take_result(7'b110_001_0, 0);

        // asynchronous reset while holding a result
        drive_beat(8'h01, 1'b1);
        #2;
        check("rst_hold_pre_valid", 7'(out_valid), 7'd1);
        rst_n = 1'b0;
        #1;
        check("rst_hold_valid", 7'(out_valid), 7'd0);
        check("rst_hold_ident", got, IDENT);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        q = '{8'hFF, 8'hFF};
        send_frame(q, 1'b0);
        take_result(7'b110_010_0, 0);

        for (int f = 0; f < 40; f++) begin
            int n = $urandom_range(1, 6);
            q.delete();
            for (int j = 0; j < n; j++) begin
                case ($urandom_range(0, 3))
                    0:       q.push_back(8'hFF);
                    1:       q.push_back(8'h00);
                    default: q.push_back(8'($urandom));
                endcase
            end
            send_frame(q, 1'b1);
            take_result(model(q), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/numbers_reduce_seq.md
Name: numbers_reduce_seq

Overview:
Frame-level reduction sequencer. Accepts a stream of DATA_W-bit words over a valid/ready handshake and passes each word through a shared word-reduction unit (AND/OR/XOR of all bits). It accumulates frame-wide AND, OR and parity across all words up to in_last, then presents one registered result beat with a valid/ready handshake. It sits between a word producer and any consumer of frame parity or all-ones/any-ones status.

Parameters:
DATA_W, 8, width of each input word (>=1)
MAX_WORDS, 16, maximum words counted per frame (>=1); longer frames are truncated
CNT_W, $clog2(MAX_WORDS+1), width of word count (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort: discard frame in progress and any pending result
in_valid  input  1  input word valid
in_ready  output  1  sequencer can accept a word
in_data  input  DATA_W  input word
in_last  input  1  final word of frame; qualified by in_valid
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_and  output  1  AND of all bits of all counted words
out_or  output  1  OR of all bits of all counted words
out_xor  output  1  XOR (parity) of all bits of all counted words
out_count  output  CNT_W  number of words counted (1..MAX_WORDS)
out_trunc  output  1  frame exceeded MAX_WORDS; extra words were discarded

Behaviour:
- Reset is asynchronous on rst_n low: state ACCUM; accumulators at identity (acc_and=1, acc_or=0, acc_xor=0, count=0, trunc=0); out_valid=0. Outputs are the accumulator registers, so out_and=1, out_or=0, out_xor=0, out_count=0, out_trunc=0 while in reset.
- in_ready = (state==ACCUM || state==DRAIN). out_valid = (state==HOLD). Neither depends combinationally on out_ready.
- Accept means in_valid && in_ready. Transfer means out_valid && out_ready.
- ACCUM, on accept:
  - acc_and &= w_and; acc_or |= w_or; acc_xor ^= w_xor, where w_* come from the word-reduction unit on in_data; count++.
  - If in_last: go to HOLD, trunc=0.
  - Else if count reaches MAX_WORDS on this beat: set trunc=1 and go to DRAIN.
  - Otherwise stay in ACCUM.
- DRAIN, on accept: the word is discarded and the accumulators are unchanged. If in_last, go to HOLD.
- HOLD: all output registers are stable. On transfer: go to ACCUM and reload identity in the same edge.
- Latency: result is visible the cycle after the in_last beat is accepted. There is a minimum of 1 bubble cycle between frames because in_ready=0 in HOLD.
- MAX_WORDS=1 with a non-last single beat: trunc=1, go to DRAIN.
- A word with in_valid=0 has no effect; in_last without in_valid is ignored.
- clr has priority over every other event in the same cycle. It forces ACCUM with identity and out_valid=0 next cycle, and any accepted beat in that cycle is dropped.
- rst_n assertion mid-frame or in HOLD drops all state immediately; there is no partial result.
- Zero-word frames cannot occur; count never exceeds MAX_WORDS; count never wraps.

Decomposition:
- Package numbers_reduce_pkg holds:
  - state enum {ACCUM, DRAIN, HOLD}
  - identity constants RED_AND_ID=1'b1, RED_OR_ID=1'b0, RED_XOR_ID=1'b0
- Sub-module numbers_reduce_word (combinational, DATA_W parameter) produces w_and, w_or, w_xor from in_data. It is instantiated once; the sequencer shares it across all words.
- FSM, counter and accumulators live in numbers_reduce_seq.

Test Plan:
- Single-beat frame: in_data=8'hFF, in_last=1 -> next cycle out_valid=1, and=1, or=1, xor=0, count=1, trunc=0.
- Two-beat frame {8'h01, 8'h03(last)} -> and=0, or=1, xor=1, count=2, trunc=0. Then frame {8'h00(last)} -> and=0, or=0, xor=0, count=1, confirming identity reload.
- MAX_WORDS=4, six-beat frame of 8'hFF with last on beat 6:
  - in_ready=1 for all 6 beats.
  - Result: and=1, or=1, xor=0, count=4, trunc=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_* stable, in_ready=0, in_valid beats not accepted. out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- clr asserted on beat 2 of a 3-beat frame with in_valid=1:
  - Beat dropped, state returns to ACCUM.
  - A following frame {8'h80(last)} gives and=0, or=1, xor=1, count=1.
- rst_n pulsed low asynchronously (between edges) mid-frame and again in HOLD -> outputs at reset values immediately and out_valid=0. The first post-reset frame is unaffected by pre-reset data.
